load_store_unit: RTL and testbench

- Sits between the CPU execute state machine and memory_bus. Takes one load/store request per handshake and drives the bus enable, write enable, address, data and write mask.
- For loads: extracts the byte/halfword lane and sign- or zero-extends it.
- For stores: replicates data across lanes and builds the active-low write mask.
- Flags misaligned accesses. Compile-time option splits them into two bus accesses instead.

---
 rtl/load_store_unit_pkg.sv | 13 +
 rtl/load_store_unit_align.sv | 35 +++
 rtl/load_store_unit.sv | 170 +++++++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: size codes, funct3 field index, FSM states and alignment helper shared by the LSU files.
package load_store_unit_pkg;
  localparam logic [1:0] LSU_SIZE_BYTE = 2'd0;
  localparam logic [1:0] LSU_SIZE_HALF = 2'd1;
  localparam logic [1:0] LSU_SIZE_WORD = 2'd2;
  localparam int LSU_F3_UNSIGNED = 2;
  typedef enum logic [2:0] {
    ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESPOND, ST_ACCESS_HI, ST_WAIT_HI
  } lsu_state_e;
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == LSU_SIZE_HALF && off[0]) || (size == LSU_SIZE_WORD && off != 2'd0);
  endfunction
endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: load lane extraction/extension over a two-word window, store lane rotation and write-mask generation.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        hi_sel,
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic [3:0]  mask
);
  logic [31:0] win;
  logic [31:0] rep;
  logic [7:0]  en;
  logic [3:0]  size_en;
  logic        sign;
  logic [1:0]  size;
  // Rotating the replicated data puts store byte k in lane (offset+k)%4, valid for both words of a split access.
  always_comb begin
    size = funct3[1:0];
    win = 32'({hi, lo} >> {offset, 3'b000});
    sign = ~funct3[LSU_F3_UNSIGNED] & (size == LSU_SIZE_BYTE ? win[7] : size == LSU_SIZE_HALF ? win[15] : win[31]);
    load_data = size == LSU_SIZE_BYTE ? {{24{sign}}, win[7:0]} :
                size == LSU_SIZE_HALF ? {{16{sign}}, win[15:0]} : win;
    rep = size == LSU_SIZE_BYTE ? {4{store_data[7:0]}} :
          size == LSU_SIZE_HALF ? {2{store_data[15:0]}} : store_data;
    store_word = 32'({rep, rep} >> (6'd32 - {1'b0, offset, 3'b000}));
    size_en = size == LSU_SIZE_BYTE ? 4'b0001 : size == LSU_SIZE_HALF ? 4'b0011 : 4'b1111;
    en = {4'b0000, size_en} << offset;
    mask = hi_sel ? ~en[7:4] : ~en[3:0];
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: load/store sequencer in front of memory_bus; LSU_MISALIGNED_SPLIT_EN turns misaligned
// half/word accesses into two bus accesses instead of errors.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [31:0]           req_data,
  output logic                  resp_valid,
  output logic [31:0]           resp_data,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic [31:0]           bus_data_in,
  output logic [3:0]            bus_write_mask,
  output logic                  bus_enable,
  output logic                  bus_write_enable,
  input  logic [31:0]           bus_data_out
);
  localparam logic [2:0] LAST = 3'(READ_LATENCY - 1);
  lsu_state_e state;
  logic        r_write;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic [2:0]  cnt;
  logic        bad_f3;
  logic        req_err;
  logic [31:0] lo_sel;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic [3:0]  mask;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic        r_mis;
  logic [31:0] lo_q;
  assign lo_sel = state == ST_WAIT_HI ? lo_q : bus_data_out;
  assign req_err = bad_f3;
`else
  assign lo_sel = bus_data_out;
  assign req_err = bad_f3 | lsu_misaligned(req_funct3[1:0], req_address[1:0]);
`endif
  assign bad_f3 = req_funct3[1:0] == 2'd3 || (req_write && req_funct3[LSU_F3_UNSIGNED]);
  // In IDLE the aligner looks at the live request so store lanes are registered on the accept edge.
  lsu_align u_align (
    .funct3     (state == ST_IDLE ? req_funct3 : r_f3),
    .offset     (state == ST_IDLE ? req_address[1:0] : r_off),
    .hi_sel     (state == ST_ACCESS),
    .lo         (lo_sel),
    .hi         (bus_data_out),
    .store_data (req_data),
    .load_data  (load_data),
    .store_word (store_word),
    .mask       (mask)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ST_IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_data <= '0;
      bus_enable <= 1'b0;
      bus_write_enable <= 1'b0;
      bus_address <= '0;
      bus_data_in <= '0;
      bus_write_mask <= 4'hF;
      r_write <= 1'b0;
      r_f3 <= '0;
      r_off <= '0;
      cnt <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_mis <= 1'b0;
      lo_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (req_valid) begin
          r_write <= req_write;
          r_f3 <= req_funct3;
          r_off <= req_address[1:0];
          req_ready <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
          r_mis <= lsu_misaligned(req_funct3[1:0], req_address[1:0]);
`endif
          if (req_err) begin
            state <= ST_RESPOND;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_data <= '0;
          end else begin
            state <= ST_ACCESS;
            bus_enable <= 1'b1;
            bus_address <= {req_address[ADDR_WIDTH-1:2], 2'b00};
            bus_write_enable <= req_write;
            if (req_write) begin
              bus_data_in <= store_word;
              bus_write_mask <= mask;
            end
          end
        end
        ST_ACCESS: begin
          cnt <= '0;
          if (!r_write) state <= ST_WAIT;
`ifdef LSU_MISALIGNED_SPLIT_EN
          else if (r_mis) begin
            state <= ST_ACCESS_HI;
            bus_address <= bus_address + ADDR_WIDTH'(4);
            bus_write_mask <= mask;
          end
`endif
          else begin
            state <= ST_RESPOND;
            resp_valid <= 1'b1;
            resp_data <= '0;
            bus_enable <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_write_mask <= 4'hF;
          end
        end
        ST_WAIT: if (cnt != LAST) cnt <= cnt + 3'd1;
`ifdef LSU_MISALIGNED_SPLIT_EN
        else if (r_mis) begin
          state <= ST_ACCESS_HI;
          lo_q <= bus_data_out;
          bus_address <= bus_address + ADDR_WIDTH'(4);
        end
`endif
        else begin
          state <= ST_RESPOND;
          resp_valid <= 1'b1;
          resp_data <= load_data;
          bus_enable <= 1'b0;
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ST_ACCESS_HI: begin
          cnt <= '0;
          if (!r_write) state <= ST_WAIT_HI;
          else begin
            state <= ST_RESPOND;
            resp_valid <= 1'b1;
            resp_data <= '0;
            bus_enable <= 1'b0;
            bus_write_enable <= 1'b0;
            bus_write_mask <= 4'hF;
          end
        end
        ST_WAIT_HI: if (cnt != LAST) cnt <= cnt + 3'd1;
        else begin
          state <= ST_RESPOND;
          resp_valid <= 1'b1;
          resp_data <= load_data;
          bus_enable <= 1'b0;
        end
`endif
        ST_RESPOND: begin
          state <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a response/bus-write scoreboard drained by a negedge monitor.
module tb_load_store_unit;
  localparam int RL = 3;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [15:0] req_address = '0;
  logic [31:0] req_data = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic [15:0] bus_address;
  logic [31:0] bus_data_in;
  logic [3:0]  bus_write_mask;
  logic        bus_enable;
  logic        bus_write_enable;
  logic [31:0] bus_data_out;
  logic [15:0] lo_addr = '0;
  logic [31:0] lo_word = '0;
  logic [31:0] hi_word = '0;
  typedef struct {logic [31:0] data; logic err; int lat;} exp_t;
  typedef struct {logic [15:0] a; logic [31:0] d; logic [3:0] m;} wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];
  exp_t me;
  wr_t  mw;
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0, en_cycles = 0;

  load_store_unit #(.READ_LATENCY(RL), .ADDR_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .bus_address(bus_address), .bus_data_in(bus_data_in), .bus_write_mask(bus_write_mask),
    .bus_enable(bus_enable), .bus_write_enable(bus_write_enable), .bus_data_out(bus_data_out)
  );

  always #5 clk = ~clk;
  assign bus_data_out = bus_address == lo_addr ? lo_word : hi_word;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (reset_n) begin
    if (bus_enable) en_cycles++;
    if (resp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
      else begin
        me = exp_q.pop_front();
        chk("resp_data", resp_data, me.data);
        chk("resp_error", {31'd0, resp_error}, {31'd0, me.err});
        chk("resp_latency", cyc - acc_cyc + 1, me.lat);
        chk("ready_low_at_resp", {31'd0, req_ready}, 32'd0);
      end
    end
    if (bus_write_enable) begin
      if (wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        mw = wr_q.pop_front();
        chk("wr_address", {16'd0, bus_address}, {16'd0, mw.a});
        chk("wr_data", bus_data_in, mw.d);
        chk("wr_mask", {28'd0, bus_write_mask}, {28'd0, mw.m});
        chk("wr_enable", {31'd0, bus_enable}, 32'd1);
      end
    end
    if (req_valid && req_ready) acc_cyc = cyc + 1;
  end

  task automatic expect_resp(input logic [31:0] d, input logic err, input int lat);
    exp_t e;
    e.data = d; e.err = err; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic expect_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
    wr_t w;
    w.a = a; w.d = d; w.m = m;
    wr_q.push_back(w);
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [15:0] a, input logic [31:0] d, input logic hold);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_funct3 = f3;
    req_address = a;
    req_data = d;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", exp_q.size() + wr_q.size(), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int snap;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_bus_enable", {31'd0, bus_enable}, 32'd0);
    chk("rst_bus_we", {31'd0, bus_write_enable}, 32'd0);
    chk("rst_bus_address", {16'd0, bus_address}, 32'd0);
    chk("rst_bus_data_in", bus_data_in, 32'd0);
    chk("rst_bus_mask", {28'd0, bus_write_mask}, 32'hF);
    reset_n = 1'b1;

    // Reset lands while the load sits in WAIT; no response may follow.
    lo_addr = 16'h4000; lo_word = 32'h80123456; hi_word = 32'h0;
    issue(1'b0, 3'b010, 16'h4000, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_bus_enable", {31'd0, bus_enable}, 32'd0);
    chk("abort_mask", {28'd0, bus_write_mask}, 32'hF);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    expect_resp(32'hFFFFFF80, 1'b0, 2 + RL);
    issue(1'b0, 3'b000, 16'h4003, 32'h0, 1'b0);
    drain();
    expect_resp(32'h00000080, 1'b0, 2 + RL);
    issue(1'b0, 3'b100, 16'h4003, 32'h0, 1'b0);
    drain();
    expect_resp(32'h00008012, 1'b0, 2 + RL);
    issue(1'b0, 3'b101, 16'h4002, 32'h0, 1'b0);
    drain();
    expect_resp(32'h00003456, 1'b0, 2 + RL);
    issue(1'b0, 3'b001, 16'h4000, 32'h0, 1'b0);
    drain();

    expect_wr(16'h4000, 32'hBEEFBEEF, 4'b0011);
    expect_resp(32'h0, 1'b0, 2);
    issue(1'b1, 3'b001, 16'h4002, 32'h0000BEEF, 1'b0);
    drain();
    expect_wr(16'h4000, 32'hA5A5A5A5, 4'b1101);
    expect_resp(32'h0, 1'b0, 2);
    issue(1'b1, 3'b000, 16'h4001, 32'h123456A5, 1'b0);
    drain();
    expect_wr(16'h4000, 32'hDEADBEEF, 4'b0000);
    expect_resp(32'h0, 1'b0, 2);
    issue(1'b1, 3'b010, 16'h4000, 32'hDEADBEEF, 1'b0);
    drain();

    snap = en_cycles;
    expect_resp(32'h0, 1'b1, 1);
    issue(1'b0, 3'b011, 16'h4000, 32'h0, 1'b0);
    drain();
    expect_resp(32'h0, 1'b1, 1);
    issue(1'b1, 3'b100, 16'h4000, 32'h55, 1'b0);
    drain();
    chk("no_bus_on_illegal", en_cycles, snap);

    lo_addr = 16'h4000; lo_word = 32'h44332211; hi_word = 32'h88776655;
`ifdef LSU_MISALIGNED_SPLIT_EN
    expect_resp(32'h55443322, 1'b0, 3 + 2 * RL);
    issue(1'b0, 3'b010, 16'h4001, 32'h0, 1'b0);
    drain();
    expect_wr(16'h4000, 32'h44112233, 4'b0111);
    expect_wr(16'h4004, 32'h44112233, 4'b1000);
    expect_resp(32'h0, 1'b0, 3);
    issue(1'b1, 3'b010, 16'h4003, 32'h11223344, 1'b0);
    drain();
    lo_addr = 16'hFFFC; lo_word = 32'hAABBCCDD; hi_word = 32'h11223344;
    expect_resp(32'h3344AABB, 1'b0, 3 + 2 * RL);
    issue(1'b0, 3'b010, 16'hFFFE, 32'h0, 1'b0);
    drain();
`else
    snap = en_cycles;
    expect_resp(32'h0, 1'b1, 1);
    issue(1'b0, 3'b010, 16'h4001, 32'h0, 1'b0);
    drain();
    expect_resp(32'h0, 1'b1, 1);
    issue(1'b1, 3'b010, 16'h4003, 32'h11223344, 1'b0);
    drain();
    expect_resp(32'h0, 1'b1, 1);
    issue(1'b0, 3'b001, 16'hFFFF, 32'h0, 1'b0);
    drain();
    chk("no_bus_on_misaligned", en_cycles, snap);
`endif

    // Back-to-back loads with req_valid held high.
    lo_addr = 16'h4000; lo_word = 32'h80123456; hi_word = 32'h0;
    expect_resp(32'h80123456, 1'b0, 2 + RL);
    expect_resp(32'h00000056, 1'b0, 2 + RL);
    expect_resp(32'h00000080, 1'b0, 2 + RL);
    issue(1'b0, 3'b010, 16'h4000, 32'h0, 1'b1);
    issue(1'b0, 3'b000, 16'h4000, 32'h0, 1'b1);
    issue(1'b0, 3'b100, 16'h4003, 32'h0, 1'b0);
    drain();

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
